// File: rtl/fast_pat_load_if.sv
// Pattern-load bundle: start/config, 32-bit word stream and memory write port.
// Master drives the load request and stream; slave is the loader itself.
interface fast_pat_load_if;
   logic         start;
   logic [10:0]  base_addr;
   logic [13:0]  word_count;
   logic [31:0]  s_data;
   logic         s_valid;
   logic         s_ready;
   logic         busy;
   logic         done;
   logic         onchip_mem_chip_select;
   logic         onchip_mem_chip_read;
   logic         onchip_mem_write;
   logic [10:0]  onchip_mem_addr;
   logic [31:0]  onchip_mem_byte_enable;
   logic [255:0] onchip_mem_write_data;
   logic [255:0] onchip_mem_readd_data;

   modport master (
      output start, base_addr, word_count, s_data, s_valid,
      output onchip_mem_readd_data,
      input  s_ready, busy, done,
      input  onchip_mem_chip_select, onchip_mem_chip_read,
      input  onchip_mem_write, onchip_mem_addr,
      input  onchip_mem_byte_enable, onchip_mem_write_data
   );

   modport slave (
      input  start, base_addr, word_count, s_data, s_valid,
      input  onchip_mem_readd_data,
      output s_ready, busy, done,
      output onchip_mem_chip_select, onchip_mem_chip_read,
      output onchip_mem_write, onchip_mem_addr,
      output onchip_mem_byte_enable, onchip_mem_write_data
   );
endinterface

// File: rtl/fast_pat_load.sv
// Packs a 32-bit word stream into 256-bit lines and writes them to on-chip memory.
// FAST_PAT_LOAD_PARTIAL_EN: final partial line uses per-word byte enables.
module fast_pat_load (
   input  logic             clk,
   input  logic             rst,
   fast_pat_load_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [13:0]   rem_q, rem_d;
   logic [2:0]    widx_q, widx_d;
   logic [10:0]   line_q, line_d;
   logic [255:0]  pack_q, pack_d;

   logic          s_ready_q, s_ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          wr_q, wr_d;
   logic [10:0]   addr_q, addr_d;
   logic [31:0]   be_q, be_d;
   logic [255:0]  wdata_q, wdata_d;

   logic          xfer;
   logic          seal;
   logic [255:0]  merged;
   logic [31:0]   be_part;
   logic          unused_rd;

   // The memory read bus is never consumed; this loader only writes.
   assign unused_rd = ^bus.onchip_mem_readd_data;

   // Word transfer, line-complete detect and the packed line with the new word.
   always_comb begin
      xfer   = (state_q == FILL) && s_ready_q && bus.s_valid;
      seal   = xfer && ((widx_q == 3'd7) || (rem_q == 14'd1));
      merged = pack_q | ({224'd0, bus.s_data} << {widx_q, 5'd0});
   end

   // Byte enables covering words 0..widx_q of the line being sealed.
   always_comb begin
      be_part = '0;
      for (int k = 0; k < 8; k++) begin
         if (3'(k) <= widx_q) begin
            be_part[4*k +: 4] = 4'hF;
         end
      end
   end

   // Next-state, datapath and registered-output next values.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      widx_d  = widx_q;
      line_d  = line_q;
      pack_d  = pack_q;
      wr_d    = 1'b0;
      addr_d  = '0;
      be_d    = '0;
      wdata_d = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               rem_d  = bus.word_count;
               line_d = bus.base_addr;
               widx_d = '0;
               pack_d = '0;
               if (bus.word_count == 14'd0) begin
                  state_d = DONE;
               end else begin
                  state_d = FILL;
               end
            end
         end
         FILL: begin
            if (xfer) begin
               rem_d = rem_q - 14'd1;
               if (seal) begin
                  wr_d    = 1'b1;
                  addr_d  = line_q;
                  wdata_d = merged;
`ifdef FAST_PAT_LOAD_PARTIAL_EN
                  be_d    = be_part;
`else
                  be_d    = '1;
`endif
                  widx_d  = '0;
                  pack_d  = '0;
                  state_d = WRITE;
               end else begin
                  widx_d  = widx_q + 3'd1;
                  pack_d  = merged;
               end
            end
         end
         WRITE: begin
            line_d = line_q + 11'd1;
            if (rem_q != 14'd0) begin
               state_d = FILL;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      s_ready_d = (state_d == FILL);
      busy_d    = (state_d != IDLE);
      done_d    = (state_q == DONE);
   end

   // State, counters and packing register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         widx_q  <= '0;
         line_q  <= '0;
         pack_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         widx_q  <= widx_d;
         line_q  <= line_d;
         pack_q  <= pack_d;
      end
   end

   // Output registers; the memory bus is zero except during a write.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
      end else begin
         s_ready_q <= s_ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
      end
   end

   assign bus.s_ready                = s_ready_q;
   assign bus.busy                   = busy_q;
   assign bus.done                   = done_q;
   assign bus.onchip_mem_chip_select = wr_q;
   assign bus.onchip_mem_write       = wr_q;
   assign bus.onchip_mem_chip_read   = 1'b0;
   assign bus.onchip_mem_addr        = addr_q;
   assign bus.onchip_mem_byte_enable = be_q;
   assign bus.onchip_mem_write_data  = wdata_q;

endmodule

// File: tb/tb_fast_pat_load.sv
// Directed and randomized loads checked against a line-level reference model.
// Honours FAST_PAT_LOAD_PARTIAL_EN for the expected partial-line byte enables.
module tb_fast_pat_load;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;

   logic [31:0]  words [0:63];
   logic [10:0]  wr_addr [$];
   logic [255:0] wr_data [$];
   logic [31:0]  wr_be [$];
   int           wr_cyc [$];
   int           done_cyc [$];
   bit           ready_seen;

   fast_pat_load_if bus ();

   fast_pat_load dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [319:0] obs,
                      input logic [319:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus monitor: records writes and done pulses, checks idle-bus rules.
   always @(negedge clk) begin
      if (bus.s_ready) ready_seen = 1'b1;
      if (bus.onchip_mem_chip_select) begin
         wr_addr.push_back(bus.onchip_mem_addr);
         wr_data.push_back(bus.onchip_mem_write_data);
         wr_be.push_back(bus.onchip_mem_byte_enable);
         wr_cyc.push_back(cyc);
         chk("wr_strobes",
             320'({bus.onchip_mem_write, bus.onchip_mem_chip_read, bus.s_ready}),
             320'(3'b100));
      end else begin
         chk("idle_bus",
             320'({bus.onchip_mem_write, bus.onchip_mem_chip_read,
                   bus.onchip_mem_addr, bus.onchip_mem_byte_enable,
                   bus.onchip_mem_write_data}),
             320'(0));
      end
      if (bus.done) done_cyc.push_back(cyc);
   end

   task automatic run_load(input logic [10:0] base, input int n,
                           input int gap, input bit alt,
                           input int glitch, input int rst_after,
                           output int scyc);
      int  idx;
      bit  took;
      bit  stopped;
      wr_addr.delete();
      wr_data.delete();
      wr_be.delete();
      wr_cyc.delete();
      done_cyc.delete();
      ready_seen = 1'b0;
      stopped = 1'b0;
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.word_count = 14'(n);
      scyc = cyc;
      @(posedge clk); #1;
      bus.start      = 1'b0;
      bus.base_addr  = 11'($urandom);
      bus.word_count = 14'($urandom);
      idx = 0;
      for (int k = 0; k < 2000; k++) begin
         if (done_cyc.size() > 0) begin
            stopped = 1'b1;
            break;
         end
         if (rst_after >= 0 && idx == rst_after) begin
            bus.s_valid = 1'b0;
            rst = 1'b1;
            stopped = 1'b1;
            break;
         end
         bus.start = (k == glitch);
         if (k == glitch) begin
            bus.base_addr  = 11'h555;
            bus.word_count = 14'd3;
         end
         bus.s_valid = (idx < n) &&
                       (alt ? (k % 2 == 0) : ($urandom_range(99) >= gap));
         bus.s_data  = (idx < n) ? words[idx] : $urandom;
         @(negedge clk);
         took = bus.s_valid && bus.s_ready;
         @(posedge clk); #1;
         if (took) idx++;
      end
      bus.start   = 1'b0;
      bus.s_valid = 1'b0;
      chk("load_finished", 320'(stopped), 320'(1));
   endtask

   task automatic check_model(input string tag, input logic [10:0] base,
                              input int n);
      int lines;
      int m;
      logic [255:0] ed;
      logic [31:0]  eb;
      lines = (n + 7) / 8;
      chk({tag, "_nwr"}, 320'(wr_addr.size()), 320'(lines));
      chk({tag, "_ndone"}, 320'(done_cyc.size()), 320'(1));
      for (int i = 0; i < lines && i < wr_addr.size(); i++) begin
         m = n - 8 * i;
         if (m > 8) m = 8;
         ed = '0;
         for (int k = 0; k < m; k++) ed[32*k +: 32] = words[8*i + k];
`ifdef FAST_PAT_LOAD_PARTIAL_EN
         eb = (m == 8) ? 32'hFFFF_FFFF : 32'((64'd1 << (4 * m)) - 64'd1);
`else
         eb = 32'hFFFF_FFFF;
`endif
         chk({tag, "_addr"}, 320'(wr_addr[i]),
             320'((int'(base) + i) % 2048));
         chk({tag, "_data"}, 320'(wr_data[i]), 320'(ed));
         chk({tag, "_be"}, 320'(wr_be[i]), 320'(eb));
      end
   endtask

   initial begin
      int sc;
      int n;
      logic [10:0] b;
      total = 0;
      bad   = 0;
      cyc   = 0;
      rst   = 1'b1;
      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.word_count = '0;
      bus.s_data     = '0;
      bus.s_valid    = 1'b0;
      bus.onchip_mem_readd_data = {8{$urandom}};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs",
          320'({bus.s_ready, bus.busy, bus.done,
                bus.onchip_mem_chip_select, bus.onchip_mem_chip_read,
                bus.onchip_mem_write, bus.onchip_mem_addr,
                bus.onchip_mem_byte_enable, bus.onchip_mem_write_data}),
          320'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      for (int k = 0; k < 8; k++) words[k] = 32'(k);
      run_load(11'h010, 8, 0, 1'b0, -1, -1, sc);
      check_model("full", 11'h010, 8);
      if (wr_cyc.size() > 0 && done_cyc.size() > 0) begin
         chk("full_done_lag", 320'(done_cyc[0] - wr_cyc[0]), 320'(2));
         chk("full_latency", 320'(wr_cyc[0] - sc), 320'(9));
      end

      for (int k = 0; k < 64; k++) words[k] = $urandom;
      run_load(11'h7FF, 16, 0, 1'b0, -1, -1, sc);
      check_model("wrap", 11'h7FF, 16);
      if (wr_cyc.size() > 1) begin
         chk("wrap_tput", 320'(wr_cyc[1] - wr_cyc[0]), 320'(9));
      end

      words[0] = 32'hA;
      words[1] = 32'hB;
      words[2] = 32'hC;
      run_load(11'h200, 3, 0, 1'b0, -1, -1, sc);
      check_model("partial", 11'h200, 3);

      run_load(11'h123, 0, 0, 1'b0, -1, -1, sc);
      chk("zero_nwr", 320'(wr_addr.size()), 320'(0));
      chk("zero_ready", 320'(ready_seen), 320'(0));
      chk("zero_ndone", 320'(done_cyc.size()), 320'(1));
      if (done_cyc.size() > 0) begin
         chk("zero_done_lag", 320'(done_cyc[0] - sc), 320'(2));
      end

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 64; k++) words[k] = $urandom;
         n = $urandom_range(40, 1);
         b = 11'($urandom);
         run_load(b, n, 30, 1'b0, -1, -1, sc);
         check_model("rand", b, n);
      end

      for (int k = 0; k < 64; k++) words[k] = $urandom;
      run_load(11'h040, 8, 0, 1'b1, -1, 5, sc);
      @(posedge clk);
      @(negedge clk);
      chk("rst_outs",
          320'({bus.s_ready, bus.busy, bus.done,
                bus.onchip_mem_chip_select, bus.onchip_mem_chip_read,
                bus.onchip_mem_write, bus.onchip_mem_addr,
                bus.onchip_mem_byte_enable, bus.onchip_mem_write_data}),
          320'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("rst_nwr", 320'(wr_addr.size()), 320'(0));
      chk("rst_ndone", 320'(done_cyc.size()), 320'(0));

      for (int k = 0; k < 64; k++) words[k] = $urandom;
      run_load(11'h041, 12, 20, 1'b0, -1, -1, sc);
      check_model("after_rst", 11'h041, 12);

      for (int k = 0; k < 64; k++) words[k] = $urandom;
      run_load(11'h100, 20, 0, 1'b0, 4, -1, sc);
      check_model("guard_fill", 11'h100, 20);

      for (int k = 0; k < 64; k++) words[k] = $urandom;
      run_load(11'h300, 20, 0, 1'b0, 8, -1, sc);
      check_model("guard_write", 11'h300, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
